// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the RV32I datapath.
// The datapath side (master) supplies instruction fields and the ALU zero flag.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;

  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       RegWrite;
  logic [2:0] ALUControl;
  logic [1:0] ImmSrc;
  logic       IllegalOp;

  modport master (
    output op, funct3, funct7b5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           RegWrite, ALUControl, ImmSrc, IllegalOp
  );

  modport slave (
    input  op, funct3, funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           RegWrite, ALUControl, ImmSrc, IllegalOp
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32I core, with ALU and immediate
// decoders feeding the shared datapath.
module multicycle_controller (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.slave bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t state;
  state_t state_next;
  state_t out_state;

  logic [1:0] alu_op;
  logic       branch;
  logic       pc_update;
  logic       ir_write;
  logic       adr_src;
  logic       mem_write;
  logic       reg_write;
  logic       illegal_op;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [1:0] imm_src;

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECUTER;
          OP_I:         state_next = S_EXECUTEI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR:   state_next = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_next = S_MEMWB;
      S_EXECUTER: state_next = S_ALUWB;
      S_EXECUTEI: state_next = S_ALUWB;
      S_JAL:      state_next = S_ALUWB;
      default:    state_next = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // While reset is held the outputs show FETCH regardless of the stored state.
  assign out_state = reset ? S_FETCH : state;

  // NOTE: every signal gets a default before the case, so no path through
  // this combinational block leaves one unassigned and infers a latch.
  always_comb begin
    alu_op     = 2'b00;
    branch     = 1'b0;
    pc_update  = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    illegal_op = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    case (out_state)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_update  = 1'b1;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (bus.op)
          OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: illegal_op = 1'b0;
          default:                                  illegal_op = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB: reg_write = 1'b1;
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      2'b01: alu_control = 3'b001;
      2'b10: begin
        case (bus.funct3)
          3'b000:  alu_control = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  always_comb begin
    imm_src = 2'b00;
    case (bus.op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // Write enables are gated so an aborted instruction never commits.
  assign bus.PCWrite    = ~reset & (pc_update | (branch & bus.Zero));
  assign bus.IRWrite    = ~reset & ir_write;
  assign bus.MemWrite   = ~reset & mem_write;
  assign bus.RegWrite   = ~reset & reg_write;
  assign bus.IllegalOp  = ~reset & illegal_op;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = alu_control;
  assign bus.ImmSrc     = imm_src;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: a driver pushes per-cycle expectations from an
// instruction-level model; a monitor pops and compares on the falling edge.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_controller_if bus ();
  multicycle_controller dut (.clk(clk), .reset(reset), .bus(bus));

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic [2:0] alu_control;
    logic [1:0] imm_src;
    logic       illegal_op;
  } vec_t;

  typedef enum {P_FETCH, P_DECODE, P_ADDR, P_LOAD, P_LOADWB, P_STORE,
                P_EXR, P_EXI, P_WB, P_JUMP, P_BRANCH} phase_t;

  typedef struct {
    vec_t  v;
    string tag;
  } exp_t;

  exp_t   exp_q[$];
  phase_t script[$];
  int     step;
  int     tests  = 0;
  int     errors = 0;

  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       cur_f7;

  task automatic check(input string name, input vec_t act, input vec_t exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %05h required %05h (pcw,adr,mw,irw,rs,sa,sb,rw,alu,imm,ill)",
               name, act, exp);
    end
  endtask

  function automatic logic supported(input logic [6:0] op);
    return op inside {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};
  endfunction

  function automatic logic [1:0] imm_for(input logic [6:0] op);
    if (op == OP_SW)  return 2'b01;
    if (op == OP_BEQ) return 2'b10;
    if (op == OP_JAL) return 2'b11;
    return 2'b00;
  endfunction

  // ALU operation an R/I arithmetic instruction asks for.
  function automatic logic [2:0] arith_for(input logic [6:0] op, input logic [2:0] f3,
                                           input logic f7);
    case (f3)
      3'b000:  return (op == OP_R && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic vec_t phase_out(input phase_t p, input logic [6:0] op,
                                     input logic [2:0] f3, input logic f7, input logic z);
    vec_t v = '0;
    v.imm_src = imm_for(op);
    case (p)
      P_FETCH:  begin v.ir_write = 1; v.alu_src_b = 2; v.result_src = 2; v.pc_write = 1; end
      P_DECODE: begin v.alu_src_a = 1; v.alu_src_b = 1; v.illegal_op = !supported(op); end
      P_ADDR:   begin v.alu_src_a = 2; v.alu_src_b = 1; end
      P_LOAD:   v.adr_src = 1;
      P_LOADWB: begin v.result_src = 1; v.reg_write = 1; end
      P_STORE:  begin v.adr_src = 1; v.mem_write = 1; end
      P_EXR:    begin v.alu_src_a = 2; v.alu_control = arith_for(op, f3, f7); end
      P_EXI:    begin v.alu_src_a = 2; v.alu_src_b = 1; v.alu_control = arith_for(op, f3, f7); end
      P_WB:     v.reg_write = 1;
      P_JUMP:   begin v.alu_src_a = 1; v.alu_src_b = 2; v.pc_write = 1; end
      P_BRANCH: begin v.alu_src_a = 2; v.alu_control = 3'b001; v.pc_write = z; end
      default:  ;
    endcase
    return v;
  endfunction

  task automatic build_script(input logic [6:0] op);
    script.delete();
    script.push_back(P_FETCH);
    script.push_back(P_DECODE);
    case (op)
      OP_LW:  begin script.push_back(P_ADDR); script.push_back(P_LOAD); script.push_back(P_LOADWB); end
      OP_SW:  begin script.push_back(P_ADDR); script.push_back(P_STORE); end
      OP_R:   begin script.push_back(P_EXR); script.push_back(P_WB); end
      OP_I:   begin script.push_back(P_EXI); script.push_back(P_WB); end
      OP_BEQ: script.push_back(P_BRANCH);
      OP_JAL: begin script.push_back(P_JUMP); script.push_back(P_WB); end
      default: ;
    endcase
  endtask

  // One clock cycle of stimulus plus the matching expectation.
  task automatic drive_cycle(input logic rst, input logic z, input string tag);
    exp_t e;
    @(posedge clk);
    #2;
    reset        = rst;
    bus.op       = cur_op;
    bus.funct3   = cur_f3;
    bus.funct7b5 = cur_f7;
    bus.Zero     = z;
    e.tag = $sformatf("%s.c%0d%s", tag, step, rst ? ".rst" : "");
    if (rst) begin
      e.v = phase_out(P_FETCH, cur_op, cur_f3, cur_f7, z);
      e.v.pc_write = 0;
      e.v.ir_write = 0;
      step = 0;
    end else begin
      e.v = phase_out(script[step], cur_op, cur_f3, cur_f7, z);
      step++;
      if (step == script.size()) step = 0;
    end
    exp_q.push_back(e);
  endtask

  // zmode: 0/1 force Zero, 2 random each cycle; abort_at < 0 means no reset.
  task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input int zmode, input int abort_at);
    logic z;
    cur_op = op;
    cur_f3 = f3;
    cur_f7 = f7;
    build_script(op);
    step = 0;
    do begin
      z = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      if (step == abort_at) begin
        drive_cycle(1'b1, z, tag);
        break;
      end
      drive_cycle(1'b0, z, tag);
    end while (step != 0);
  endtask

  initial begin
    exp_t e;
    vec_t act;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        act = '{bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
                bus.ALUSrcA, bus.ALUSrcB, bus.RegWrite, bus.ALUControl, bus.ImmSrc,
                bus.IllegalOp};
        check(e.tag, act, e.v);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ops [6];
    logic [6:0] rop;
    int         wait_cycles;
    ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_R;
    ops[3] = OP_I;  ops[4] = OP_BEQ; ops[5] = OP_JAL;

    reset = 1'b1;
    bus.op = OP_R; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0; bus.Zero = 1'b0;
    cur_op = OP_R; cur_f3 = 3'b000; cur_f7 = 1'b0;
    build_script(OP_R);
    step = 0;
    repeat (3) drive_cycle(1'b1, 1'b0, "reset");

    run_instr("lw",        OP_LW,  3'b010, 1'b1, 2, -1);
    run_instr("sw",        OP_SW,  3'b010, 1'b0, 2, -1);
    run_instr("r_sub",     OP_R,   3'b000, 1'b1, 2, -1);
    run_instr("addi_b30",  OP_I,   3'b000, 1'b1, 2, -1);
    run_instr("r_slt",     OP_R,   3'b010, 1'b0, 2, -1);
    run_instr("r_or",      OP_R,   3'b110, 1'b0, 2, -1);
    run_instr("r_and",     OP_R,   3'b111, 1'b1, 2, -1);
    run_instr("i_and",     OP_I,   3'b111, 1'b0, 2, -1);
    run_instr("beq_taken", OP_BEQ, 3'b000, 1'b0, 1, -1);
    run_instr("beq_not",   OP_BEQ, 3'b000, 1'b0, 0, -1);
    run_instr("jal",       OP_JAL, 3'b101, 1'b1, 1, -1);
    run_instr("illegal",   7'b0000000, 3'b000, 1'b0, 1, -1);
    run_instr("sw_abort",  OP_SW,  3'b010, 1'b0, 1, 3);
    run_instr("lw_abort",  OP_LW,  3'b010, 1'b0, 1, 4);
    run_instr("jal_abort", OP_JAL, 3'b000, 1'b0, 1, 2);
    run_instr("after_rst", OP_R,   3'b000, 1'b0, 1, -1);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) rop = 7'($urandom);
      else                           rop = ops[$urandom_range(0, 5)];
      run_instr($sformatf("rnd%0d", i), rop, 3'($urandom), 1'($urandom),
                2, ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1);
    end

    wait_cycles = 0;
    while (exp_q.size() != 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
